output_bram_streamer: RTL and testbench

//  Transmit-side counterpart of the kernel-load path. Captures conv output pixels into a local

---
 rtl/output_bram_streamer_if.sv | 23 ++
 rtl/output_bram_streamer.sv | 155 +++++++++++++++
 tb/tb_output_bram_streamer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/output_bram_streamer_if.sv
// AXI4-Stream bundle between output_bram_streamer (master) and its consumer (slave).
interface output_bram_streamer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/output_bram_streamer.sv
// output_bram_streamer: captures conv output pixels into a local BRAM, then streams the
// frame out over an AXI4-Stream master with tlast on the final pixel.
// Optional build macro OUT_RELU_EN: negative pixels are replaced by zero on the read path.
module output_bram_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  load_BRAM_dina,
    input  logic [DATA_WIDTH-1:0] out_BRAM_dina,
    input  logic [ADDR_WIDTH:0]   PIXEL_COUNT,
    input  logic                  start_stream,
    output logic                  last_write,
    output logic                  Out_BRAM_IDLE,
    output logic                  stream_done,
    output_bram_streamer_if.master axis
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state;
    // Counters are one bit wider than the BRAM address so a full 2**ADDR_WIDTH frame
    // reaches its final pixel without wrapping.
    logic [ADDR_WIDTH:0]   waddr;
    logic [ADDR_WIDTH:0]   raddr;
    logic [ADDR_WIDTH:0]   beat_cnt;
    logic [ADDR_WIDTH:0]   pc_last;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] push_data;

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_valid;

    logic                  wr_en;
    logic                  pop;
    logic                  issue;
    logic [1:0]            pending;

    assign pc_last       = PIXEL_COUNT - CNT_ONE;
    assign wr_en         = !Reset && (state == S_IDLE) && load_BRAM_dina;
    assign last_write    = wr_en && (waddr == pc_last);
    assign Out_BRAM_IDLE = (state == S_IDLE);
    assign stream_done   = (state == S_DONE);

    assign pop = out_valid && axis.m_axis_tready;

    // Entries that will sit in the output buffer after this edge: current contents, minus
    // the beat leaving now, plus the read landing now. Counting the departing beat lets a
    // new read issue every cycle while the consumer keeps up, so there are no bubbles.
    assign pending = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_valid} - {1'b0, pop};
    assign issue   = (state == S_STREAM) && (raddr < PIXEL_COUNT) && (pending < 2'd2);

`ifdef OUT_RELU_EN
    assign push_data = rd_data[DATA_WIDTH-1] ? '0 : rd_data;
`else
    assign push_data = rd_data;
`endif

    assign axis.m_axis_tdata  = out_data;
    assign axis.m_axis_tvalid = out_valid;
    assign axis.m_axis_tlast  = out_valid && (beat_cnt == pc_last);

    // Pixel storage: write port from the conv datapath, registered read port for the stream.
    // NOTE: the pixel array has no reset on purpose; frame contents survive Reset and an
    // unreset array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr[ADDR_WIDTH-1:0]] <= out_BRAM_dina;
        end
        if (issue) begin
            rd_data <= mem[raddr[ADDR_WIDTH-1:0]];
        end
    end

    // Control FSM with write, read and beat counters.
    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            waddr    <= '0;
            raddr    <= '0;
            beat_cnt <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= issue;
            if (issue) begin
                raddr <= raddr + CNT_ONE;
            end
            case (state)
                S_IDLE: begin
                    // A write in the same cycle as start_stream still lands at this edge,
                    // and the first read is issued only in the following cycle.
                    if (wr_en) begin
                        waddr <= last_write ? '0 : waddr + CNT_ONE;
                    end
                    if (start_stream && (PIXEL_COUNT != '0)) begin
                        state    <= S_STREAM;
                        raddr    <= '0;
                        beat_cnt <= '0;
                    end
                end
                S_STREAM: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + CNT_ONE;
                        if (axis.m_axis_tlast) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    raddr    <= '0;
                    beat_cnt <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-entry output buffer: the output register holds still while stalled, and the skid
    // register catches the read that was already in flight.
    always_ff @(posedge clk) begin
        if (Reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (pop || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= rd_valid;
                skid_data  <= push_data;
            end else begin
                out_valid <= rd_valid;
                out_data  <= push_data;
            end
        end else if (rd_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= push_data;
        end
    end

endmodule

// File: tb/tb_output_bram_streamer.sv
// Directed bench for output_bram_streamer: frame capture, streaming under several tready
// patterns, ignored requests, reset mid-stream and the optional OUT_RELU_EN read path.
module tb_output_bram_streamer;

    logic        clk;
    logic        Reset;
    logic        load_BRAM_dina;
    logic [15:0] out_BRAM_dina;
    logic [8:0]  PIXEL_COUNT;
    logic        start_stream;
    logic        last_write;
    logic        Out_BRAM_IDLE;
    logic        stream_done;

    int checks;
    int errors;

    // Expected BRAM contents and write pointer, tracked by the bench.
    logic [15:0] exp_mem [256];
    int          wa;

    output_bram_streamer_if #(.DATA_WIDTH(16)) axis ();

    output_bram_streamer dut (
        .clk            (clk),
        .Reset          (Reset),
        .load_BRAM_dina (load_BRAM_dina),
        .out_BRAM_dina  (out_BRAM_dina),
        .PIXEL_COUNT    (PIXEL_COUNT),
        .start_stream   (start_stream),
        .last_write     (last_write),
        .Out_BRAM_IDLE  (Out_BRAM_IDLE),
        .stream_done    (stream_done),
        .axis           (axis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input logic [15:0] d);
`ifdef OUT_RELU_EN
        return d[15] ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pixel(input logic [15:0] d);
        load_BRAM_dina = 1'b1;
        out_BRAM_dina  = d;
        #1;
        chk("last_write", {31'd0, last_write}, {31'd0, (wa == int'(PIXEL_COUNT) - 1)});
        tick();
        load_BRAM_dina = 1'b0;
        exp_mem[wa] = d;
        wa = (wa == int'(PIXEL_COUNT) - 1) ? 0 : wa + 1;
    endtask

    // mode 0: tready=1, mode 1: tready 1,0,0,1 repeating, mode 2: random tready.
    // poke drives load_BRAM_dina with junk during the stream.
    task automatic run_stream(input int n, input int mode, input bit poke, input string tag);
        int          got;
        int          cyc;
        int          first_v;
        int          last_v;
        bit          stall;
        bit          rdy;
        logic [15:0] sd;
        logic        sl;
        got = 0; cyc = 0; first_v = -1; last_v = -1; stall = 0; sd = '0; sl = 1'b0;
        start_stream = 1'b1;
        tick();
        start_stream = 1'b0;
        chk({tag, " busy"}, {31'd0, Out_BRAM_IDLE}, 32'd0);
        while (got < n && cyc < n * 8 + 20) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            axis.m_axis_tready = rdy;
            load_BRAM_dina     = poke && (cyc >= 1) && (cyc <= 4);
            out_BRAM_dina      = 16'hDEAD;
            if (stall) begin
                chk({tag, " stall tvalid"}, {31'd0, axis.m_axis_tvalid}, 32'd1);
                chk({tag, " stall tdata"}, {16'd0, axis.m_axis_tdata}, {16'd0, sd});
                chk({tag, " stall tlast"}, {31'd0, axis.m_axis_tlast}, {31'd0, sl});
            end
            stall = 1'b0;
            if (axis.m_axis_tvalid) begin
                if (first_v < 0) first_v = cyc;
                if (rdy) begin
                    chk({tag, " tdata"}, {16'd0, axis.m_axis_tdata}, {16'd0, exp_pix(exp_mem[got])});
                    chk({tag, " tlast"}, {31'd0, axis.m_axis_tlast}, {31'd0, (got == n - 1)});
                    got++;
                    last_v = cyc;
                end else begin
                    stall = 1'b1;
                    sd    = axis.m_axis_tdata;
                    sl    = axis.m_axis_tlast;
                end
            end
            tick();
            cyc++;
        end
        load_BRAM_dina     = 1'b0;
        axis.m_axis_tready = 1'b0;
        chk({tag, " beat count"}, got, n);
        if (mode == 0) begin
            chk({tag, " first tvalid cycle"}, first_v, 2);
            chk({tag, " no bubbles"}, last_v - first_v, n - 1);
        end
        chk({tag, " stream_done"}, {31'd0, stream_done}, 32'd1);
        chk({tag, " tvalid after tlast"}, {31'd0, axis.m_axis_tvalid}, 32'd0);
        tick();
        chk({tag, " stream_done pulse"}, {31'd0, stream_done}, 32'd0);
        chk({tag, " back to idle"}, {31'd0, Out_BRAM_IDLE}, 32'd1);
    endtask

    initial begin
        int got;
        int cyc;
        checks = 0;
        errors = 0;
        wa = 0;
        Reset = 1'b1;
        load_BRAM_dina = 1'b0;
        out_BRAM_dina = '0;
        PIXEL_COUNT = 9'd16;
        start_stream = 1'b0;
        axis.m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;

        // Reset state
        chk("rst idle", {31'd0, Out_BRAM_IDLE}, 32'd1);
        chk("rst tvalid", {31'd0, axis.m_axis_tvalid}, 32'd0);
        chk("rst tlast", {31'd0, axis.m_axis_tlast}, 32'd0);
        chk("rst tdata", {16'd0, axis.m_axis_tdata}, 32'd0);
        chk("rst stream_done", {31'd0, stream_done}, 32'd0);
        chk("rst last_write", {31'd0, last_write}, 32'd0);

        // 1) 16 pixels 0x0001..0x0010, full-rate stream
        for (int i = 0; i < 16; i++) write_pixel(16'(i + 1));
        run_stream(16, 0, 1'b0, "t1");

        // 2) Same frame with tready 1,0,0,1
        run_stream(16, 1, 1'b0, "t2");

        // 4a) start_stream with PIXEL_COUNT=0 is ignored
        PIXEL_COUNT = 9'd0;
        start_stream = 1'b1;
        tick();
        start_stream = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("pc0 tvalid", {31'd0, axis.m_axis_tvalid}, 32'd0);
            chk("pc0 idle", {31'd0, Out_BRAM_IDLE}, 32'd1);
            tick();
        end
        PIXEL_COUNT = 9'd16;

        // 4b) Writes during STREAM are ignored; the re-stream shows the original frame
        run_stream(16, 0, 1'b1, "t4 poke");
        run_stream(16, 2, 1'b0, "t4 restream");

        // 3) Full-depth frame 0..255 with random tready
        PIXEL_COUNT = 9'd256;
        for (int i = 0; i < 256; i++) write_pixel(16'(i));
        run_stream(256, 2, 1'b0, "t3");

        // 5) Reset after beat 5 of 16, then a fresh stream from pixel 0
        PIXEL_COUNT = 9'd16;
        for (int i = 0; i < 16; i++) write_pixel(16'(16'h0100 + i));
        start_stream = 1'b1;
        tick();
        start_stream = 1'b0;
        axis.m_axis_tready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 50) begin
            if (axis.m_axis_tvalid) got++;
            tick();
            cyc++;
        end
        chk("t5 beats before reset", got, 5);
        Reset = 1'b1;
        tick();
        chk("t5 tvalid after reset", {31'd0, axis.m_axis_tvalid}, 32'd0);
        chk("t5 idle after reset", {31'd0, Out_BRAM_IDLE}, 32'd1);
        chk("t5 tlast after reset", {31'd0, axis.m_axis_tlast}, 32'd0);
        Reset = 1'b0;
        axis.m_axis_tready = 1'b0;
        wa = 0;
        tick();
        run_stream(16, 0, 1'b0, "t5 restream");

        // 6) Sign handling on the read path
        PIXEL_COUNT = 9'd3;
        write_pixel(16'h8000);
        write_pixel(16'hFFFF);
        write_pixel(16'h7FFF);
        run_stream(3, 0, 1'b0, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
